// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//   User-interface controller that sequences setting the time on the
//   HH:MM:SS BCD counter chain. The first mode press freezes the chain and
//   copies the live hour/minute digits into shadow registers. The hour is
//   edited first, then the minute. The last mode press sends a one-cycle load
//   strobe to every counter. Seconds are always loaded as 00. If no button
//   edge arrives for TIMEOUT_SEC seconds, the edit is abandoned and the chain
//   resumes from the values it was holding.
//
// Optional build macro:
//   AUTO_REPEAT_EN - an inc button held across two sec_ticks after its edge
//                    adds one increment on every later sec_tick.
//
// Parameters:
//   TIMEOUT_SEC   seconds without a button edge before an edit is dropped (1..255)
//
// Ports:
//   clk                     system clock
//   rst                     asynchronous reset, active low
//   sec_tick                one-clk pulse per second
//   mode_btn, inc_btn       debounced button levels
//   cur_hr_t .. cur_min_u   live BCD digits from the counters
//   run_en                  1 = counter chain may count
//   set                     one-cycle load strobe to all counters
//   set_hr_t .. set_min_u   load values, qualified by set
//   set_sec_t, set_sec_u    always 0
//   field                   0 RUN, 1 SET_HR, 2 SET_MIN, 3 COMMIT
//   blink                   blink enable for the field being edited
// -----------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_hr_t,
  input  logic [3:0] cur_hr_u,
  input  logic [3:0] cur_min_t,
  input  logic [3:0] cur_min_u,
  output logic       run_en,
  output logic       set,
  output logic [3:0] set_hr_t,
  output logic [3:0] set_hr_u,
  output logic [3:0] set_min_t,
  output logic [3:0] set_min_u,
  output logic [3:0] set_sec_t,
  output logic [3:0] set_sec_u,
  output logic [1:0] field,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_SEC - 1);

  state_t     state, state_nxt;
  logic       mode_q, inc_q, mode_e, inc_e;
  logic       editing, inc_do, rep_inc, any_edge, timeout_hit, cap_bad;
  logic [3:0] sh_hr_t, sh_hr_u, sh_min_t, sh_min_u;
  logic [3:0] hr_inc_t, hr_inc_u, min_inc_t, min_inc_u;
  logic [7:0] to_cnt;
  logic       blink_r;

  // Button edges. The *_q registers reset to 1, so a button that is held
  // through reset does not look like a press when reset is released.
  assign mode_e  = mode_btn & ~mode_q;
  assign inc_e   = inc_btn & ~inc_q;
  assign editing = (state == SET_HR) || (state == SET_MIN);

  // When mode and inc arrive together, mode wins and the increment is dropped.
  assign inc_do      = editing & ~mode_e & (inc_e | rep_inc);
  assign any_edge    = mode_e | inc_e | rep_inc;
  assign timeout_hit = editing & sec_tick & ~any_edge & (to_cnt == TO_LAST);

  // A captured time that is not a legal 24h BCD time is replaced by 00:00.
  assign cap_bad = (cur_hr_t > 4'd9) || (cur_hr_u > 4'd9) ||
                   (cur_min_t > 4'd9) || (cur_min_u > 4'd9) ||
                   (cur_hr_t > 4'd2) || ((cur_hr_t == 4'd2) && (cur_hr_u > 4'd3)) ||
                   (cur_min_t > 4'd5);

`ifdef AUTO_REPEAT_EN
  // Auto-repeat. After an inc edge in an edit state, the first two sec_ticks
  // arm the repeat. Each later tick adds one increment while inc stays held.
  logic       rep_act;
  logic [1:0] rep_cnt;

  assign rep_inc = editing & rep_act & inc_btn & sec_tick & (rep_cnt == 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_act <= 1'b0;
      rep_cnt <= 2'd0;
    end else if ((state_nxt != state) || !inc_btn) begin
      rep_act <= 1'b0;
      rep_cnt <= 2'd0;
    end else if (inc_e && editing) begin
      rep_act <= 1'b1;
      rep_cnt <= 2'd0;
    end else if (rep_act && sec_tick && (rep_cnt != 2'd2)) begin
      rep_cnt <= rep_cnt + 2'd1;
    end
  end
`else
  assign rep_inc = 1'b0;
`endif

  // BCD increments of the shadow hour (23 -> 00) and minute (59 -> 00).
  // The minute does not carry into the hour.
  always_comb begin
    hr_inc_t  = sh_hr_t;
    hr_inc_u  = sh_hr_u + 4'd1;
    min_inc_t = sh_min_t;
    min_inc_u = sh_min_u + 4'd1;
    if ((sh_hr_t == 4'd2) && (sh_hr_u == 4'd3)) begin
      hr_inc_t = 4'd0;
      hr_inc_u = 4'd0;
    end else if (sh_hr_u == 4'd9) begin
      hr_inc_t = sh_hr_t + 4'd1;
      hr_inc_u = 4'd0;
    end
    if (sh_min_u == 4'd9) begin
      min_inc_u = 4'd0;
      min_inc_t = (sh_min_t == 4'd5) ? 4'd0 : sh_min_t + 4'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Next-state logic. COMMIT lasts exactly one cycle. A timeout returns to
  // RUN without a load strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mode_e) state_nxt = SET_HR;
      SET_HR:  if (mode_e) state_nxt = SET_MIN;
               else if (timeout_hit) state_nxt = RUN;
      SET_MIN: if (mode_e) state_nxt = COMMIT;
               else if (timeout_hit) state_nxt = RUN;
      COMMIT:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Edge registers, shadow time, timeout counter, blink phase and the held
  // load values. The load values are written on the way into COMMIT so that
  // they are already valid in the cycle where set is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= 1'b1;
      inc_q     <= 1'b1;
      sh_hr_t   <= 4'd0;
      sh_hr_u   <= 4'd0;
      sh_min_t  <= 4'd0;
      sh_min_u  <= 4'd0;
      to_cnt    <= 8'd0;
      blink_r   <= 1'b0;
      set_hr_t  <= 4'd0;
      set_hr_u  <= 4'd0;
      set_min_t <= 4'd0;
      set_min_u <= 4'd0;
    end else begin
      mode_q <= mode_btn;
      inc_q  <= inc_btn;

      if ((state == RUN) && mode_e) begin
        sh_hr_t  <= cap_bad ? 4'd0 : cur_hr_t;
        sh_hr_u  <= cap_bad ? 4'd0 : cur_hr_u;
        sh_min_t <= cap_bad ? 4'd0 : cur_min_t;
        sh_min_u <= cap_bad ? 4'd0 : cur_min_u;
      end else if (inc_do && (state == SET_HR)) begin
        sh_hr_t <= hr_inc_t;
        sh_hr_u <= hr_inc_u;
      end else if (inc_do && (state == SET_MIN)) begin
        sh_min_t <= min_inc_t;
        sh_min_u <= min_inc_u;
      end

      if (!editing || any_edge) to_cnt <= 8'd0;
      else if (sec_tick)        to_cnt <= to_cnt + 8'd1;

      if (!editing)      blink_r <= 1'b0;
      else if (sec_tick) blink_r <= ~blink_r;

      if ((state == SET_MIN) && mode_e) begin
        set_hr_t  <= sh_hr_t;
        set_hr_u  <= sh_hr_u;
        set_min_t <= sh_min_t;
        set_min_u <= sh_min_u;
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    run_en    = (state == RUN);
    set       = (state == COMMIT);
    field     = state;
    blink     = blink_r & editing;
    set_sec_t = 4'd0;
    set_sec_u = 4'd0;
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//   Testbench for time_set_ctrl. It builds with TIMEOUT_SEC = 3.
//   A time-level reference model (hour 0..23 and minute 0..59 as integers)
//   advances once per cycle from the stimulus process. Each commit pushes
//   the expected load time into a queue. A monitor process compares the DUT
//   outputs with the model on every falling edge. It pops the queue whenever
//   the DUT raises set.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst, sec_tick, mode_btn, inc_btn;
  logic [3:0] cur_hr_t, cur_hr_u, cur_min_t, cur_min_u;
  logic       run_en, set, blink;
  logic [3:0] set_hr_t, set_hr_u, set_min_t, set_min_u, set_sec_t, set_sec_u;
  logic [1:0] field;

  time_set_ctrl #(.TIMEOUT_SEC(TO)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_hr_t(cur_hr_t), .cur_hr_u(cur_hr_u),
    .cur_min_t(cur_min_t), .cur_min_u(cur_min_u),
    .run_en(run_en), .set(set),
    .set_hr_t(set_hr_t), .set_hr_u(set_hr_u),
    .set_min_t(set_min_t), .set_min_u(set_min_u),
    .set_sec_t(set_sec_t), .set_sec_u(set_sec_u),
    .field(field), .blink(blink)
  );

  always #5 clk = ~clk;

  // Reference model state: the edit phase, the shadow time as integers,
  // seconds since the last edge, the blink phase, the last committed time
  // and the previous button levels.
  int  m_field, m_hour, m_min, m_to, s_hour, s_min;
  bit  m_blink, pm, pi;
  int  exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  done = 1'b0;

  function automatic int bcd2(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic modelReset();
    m_field = 0; m_hour = 0; m_min = 0; m_to = 0;
    s_hour = 0; s_min = 0; m_blink = 1'b0; pm = 1'b1; pi = 1'b1;
  endtask

  // Advance the model by one clock, using the inputs applied for that clock.
  task automatic modelStep(input bit m, input bit i, input bit t);
    bit me, ie;
    int h, mn;
    me = m & !pm;
    ie = i & !pi;
    pm = m;
    pi = i;
    if (m_field == 1 || m_field == 2) begin
      if (t) m_blink = !m_blink;
    end else begin
      m_blink = 1'b0;
    end
    case (m_field)
      0: if (me) begin
        h  = int'(cur_hr_t) * 10 + int'(cur_hr_u);
        mn = int'(cur_min_t) * 10 + int'(cur_min_u);
        if (cur_hr_t > 9 || cur_hr_u > 9 || cur_min_t > 9 || cur_min_u > 9 ||
            h > 23 || mn > 59) begin
          h = 0;
          mn = 0;
        end
        m_hour = h; m_min = mn; m_to = 0; m_field = 1;
      end
      1, 2: if (me) begin
        m_to = 0;
        if (m_field == 1) m_field = 2;
        else begin
          m_field = 3;
          s_hour = m_hour;
          s_min = m_min;
          exp_q.push_back(m_hour * 100 + m_min);
        end
      end else if (ie) begin
        m_to = 0;
        if (m_field == 1) m_hour = (m_hour + 1) % 24;
        else              m_min  = (m_min + 1) % 60;
      end else if (t) begin
        m_to++;
        if (m_to == TO) begin
          m_field = 0;
          m_to = 0;
        end
      end
      default: m_field = 0;
    endcase
  endtask

  // Drive one clock of stimulus just after a falling edge and step the model.
  task automatic applyStimulus(input bit m, input bit i, input bit t);
    @(negedge clk);
    #1;
    mode_btn = m;
    inc_btn  = i;
    sec_tick = t;
    modelStep(m, i, t);
  endtask

  task automatic press(input bit m, input bit i);
    applyStimulus(m, i, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit t);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, t);
  endtask

  task automatic setCur(input int ht, input int hu, input int mt, input int mu);
    cur_hr_t  = 4'(ht);
    cur_hr_u  = 4'(hu);
    cur_min_t = 4'(mt);
    cur_min_u = 4'(mu);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor and scoreboard. This is the only process that counts checks.
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    int e;
    bit ed;
    ed = (m_field == 1 || m_field == 2);
    chk("field", int'(field), m_field);
    chk("run_en", int'(run_en), int'(m_field == 0));
    chk("set", int'(set), int'(m_field == 3));
    chk("blink", int'(blink), int'(ed & m_blink));
    chk("set_hr_hold", int'({set_hr_t, set_hr_u}), bcd2(s_hour));
    chk("set_min_hold", int'({set_min_t, set_min_u}), bcd2(s_min));
    chk("set_sec", int'({set_sec_t, set_sec_u}), 0);
    if (set === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_set", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_commit", int'({set_hr_t, set_hr_u, set_min_t, set_min_u}),
            (bcd2(e / 100) << 8) | bcd2(e % 100));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput();
      if (done) begin
        chk("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, h, mn;
    rst = 1'b0;
    mode_btn = 1'b1;
    inc_btn = 1'b1;
    sec_tick = 1'b0;
    setCur(1, 2, 3, 4);
    modelReset();
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;

    // Buttons held through reset give no edge.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idle(2, 1'b0);

    // 12:34 -> 15:36
    press(1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (2) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    idle(2, 1'b0);

    // Hour wrap 22 -> 00
    setCur(2, 2, 0, 0);
    press(1'b1, 1'b0);
    repeat (2) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    idle(1, 1'b0);

    // Minute wrap 58 -> 00 with the hour kept at 10
    setCur(1, 0, 5, 8);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (2) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    idle(1, 1'b0);

    // Invalid capture 27:61 -> 00:00
    setCur(2, 7, 6, 1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    idle(1, 1'b0);

    // Timeout after three ticks, then a press restarts the count
    setCur(0, 9, 4, 5);
    press(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    press(1'b1, 1'b0);
    idle(2, 1'b1);
    press(1'b0, 1'b1);
    idle(2, 1'b1);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Simultaneous mode and inc in SET_HR: advance without an hour change
    setCur(0, 8, 1, 5);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    press(1'b1, 1'b0);
    idle(1, 1'b0);

    // Reset in the middle of SET_MIN discards the edit
    setCur(1, 1, 1, 1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    doReset();
    idle(2, 1'b0);

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        setCur($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
      end else begin
        h  = $urandom_range(0, 23);
        mn = $urandom_range(0, 59);
        setCur(h / 10, h % 10, mn / 10, mn % 10);
      end
      press(1'b1, $urandom_range(0, 1) == 1);
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        applyStimulus(1'b0, 1'b1, $urandom_range(0, 3) == 0);
        applyStimulus(1'b0, 1'b0, $urandom_range(0, 3) == 0);
      end
      press(1'b1, $urandom_range(0, 7) == 0);
      n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) begin
        applyStimulus(1'b0, 1'b1, $urandom_range(0, 3) == 0);
        applyStimulus(1'b0, 1'b0, $urandom_range(0, 3) == 0);
      end
      press(1'b1, 1'b0);
      idle($urandom_range(1, 3), $urandom_range(0, 1) == 1);
    end

    idle(2, 1'b0);
    @(negedge clk);
    #1;
    done = 1'b1;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User-interface controller that sequences time setting of the HH:MM:SS BCD counter chain.
- Takes debounced mode/inc buttons and the live counter digits, and holds the chain stopped while the user edits hours then minutes in shadow registers.
- Commits the edit with a one-cycle load pulse to all counters. Seconds are always loaded as 00.
- Sits between the button debouncers and the second-tick/bcd counter datapath.

Parameters:
- TIMEOUT_SEC, 10, number of sec_tick pulses with no button edge after which an edit is abandoned (range 1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sec_tick  in  1  one-clk-wide pulse per second, synchronous to clk.
- mode_btn  in  1  debounced level, synchronous to clk.
- inc_btn  in  1  debounced level, synchronous to clk.
- cur_hr_t, cur_hr_u, cur_min_t, cur_min_u  in  4 each  live BCD digits from the counters.
- run_en  out  1  gates sec_tick into the counter chain; 1 = counting.
- set  out  1  one-cycle load strobe to all counters.
- set_hr_t, set_hr_u, set_min_t, set_min_u  out  4 each  load values; valid whenever set=1.
- set_sec_t, set_sec_u  out  4 each  constant 0.
- field  out  2  0 = RUN, 1 = SET_HR, 2 = SET_MIN, 3 = COMMIT.
- blink  out  1  display blink for the field being edited.

Behaviour:
- Reset (rst=0, asynchronous): state RUN, run_en=1, set=0, all set_* = 0, shadow = 00:00, blink=0, timeout counter=0, edge-detect registers=1. The edge-detect reset value of 1 means a button held through reset produces no edge.
- Edge detect: mode_e = mode_btn & ~mode_q, inc_e = inc_btn & ~inc_q, with registered *_q. Each edge is a one-cycle event.
- If mode_e and inc_e occur in the same cycle, mode_e is acted on and inc_e is discarded.
- RUN: run_en=1.
  - On mode_e, capture the cur_* digits into shadow and go to SET_HR on the next cycle.
  - If the captured value is invalid, shadow becomes 00:00. Invalid means any digit > 9, hr_t > 2, hr_t = 2 with hr_u > 3, or min_t > 5.
- SET_HR: run_en=0.
  - inc_e increments the shadow hour in BCD: unit 9 -> 0 with tens+1; 23 -> 00.
  - mode_e -> SET_MIN.
- SET_MIN: run_en=0.
  - inc_e increments the shadow minute: 59 -> 00. There is no carry into the hour.
  - mode_e -> COMMIT.
- COMMIT: lasts exactly one cycle.
  - set=1, set_hr/min = shadow, set_sec = 0, run_en=0.
  - Next cycle: RUN, with set=0 and run_en=1.
- Shadow updates take effect the cycle after the edge. Total latency from mode_e in SET_MIN to set=1 is 1 cycle.
- Timeout (SET_HR/SET_MIN only):
  - The counter clears on entry to either state and on any mode_e or inc_e.
  - It increments on sec_tick. When it reaches TIMEOUT_SEC, go to RUN with no set pulse; the counters resume from their held values.
  - If sec_tick and a button edge occur in the same cycle, the edge wins and the counter clears.
- blink: toggles on each sec_tick in SET_HR/SET_MIN; forced to 0 in RUN and COMMIT.
- set_* outputs hold their last values outside COMMIT. Only set qualifies them.
- Reset asserted mid-edit: the edit is discarded immediately and no set pulse is issued.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: in SET_HR/SET_MIN, if inc_btn stays high across 2 consecutive sec_ticks after its edge, one extra increment occurs on each later sec_tick while it is still held.
  - These repeats clear the timeout counter.
  - Repeat tracking resets on inc_btn low or any state change.
- Undefined: increments occur only on inc_e; holding the button has no further effect.

Test Plan:
- Reset with inc_btn/mode_btn held high, then release rst -> no state change; field=0, run_en=1, set=0.
- cur=12:34, press mode, inc x3, mode, inc x2, mode -> single set pulse with set_hr=1,5, set_min=3,6, set_sec=0,0; run_en=0 for the whole edit; field returns to 0 one cycle after COMMIT.
- Hour wrap: capture 22:00, inc x2 in SET_HR -> shadow hour 00. Minute wrap: capture 10:58, inc x2 in SET_MIN -> minute 00 and hour stays 10.
- Invalid capture cur=2,7:6,1 -> shadow 00:00; committing with no inc gives set_hr=0,0 and set_min=0,0.
- Timeout with TIMEOUT_SEC=3: enter SET_HR, apply 3 sec_ticks with no edges -> RUN, no set pulse. A press between ticks restarts the count, so timeout needs 3 more ticks.
- Simultaneous mode_e and inc_e in SET_HR -> moves to SET_MIN and the hour is unchanged. Asserting rst mid-SET_MIN -> field=0, set never pulses.
